song_sequencer: RTL and testbench
=================================

// Module: song_sequencer
// PURPOSE
//  Playback controller for the 32-note song held by the song editor. In play mode it
//  snapshots the two note words on start, runs a beat timer, and counts down before play.
//  It then steps through the song one note per beat and emits each note to the lane/scoring
//  logic. Supports pause/resume and aborts when the game leaves play mode.
// PARAMETERS
//  BEAT_CYCLES      25     clk cycles per beat (>=2); counter width $clog2(BEAT_CYCLES)
//  COUNTDOWN_BEATS  3      beats of count-in before first note (1..3)
//  SONG_LEN         32     notes played per song (1..32)
//  PLAY_MODE        3'd3   mode value that enables playback
// PORTS
//  clk         in   1   system clock
//  nrst        in   1   async active-low reset
//  mode        in   3   game mode; playback runs only while mode==PLAY_MODE
//  start       in   1   one-cycle strobe, starts playback from IDLE
//  pause       in   1   one-cycle strobe, toggles pause while busy
//  note1       in   32  song word 0: note p (p<16) = note1[2p+1:2p]
//  note2       in   32  song word 1: note p (p>=16) = note2[2(p-16)+1:2(p-16)]
//  cur_note    out  2   last emitted note code (registered)
//  note_valid  out  1   one-cycle pulse, cur_note/play_pos updated this cycle
//  play_pos    out  5   index of last emitted note
//  countdown   out  2   remaining count-in beats (0 outside COUNTDOWN)
//  busy        out  1   state is COUNTDOWN, PLAY or PAUSED
//  paused      out  1   state is PAUSED
//  done        out  1   one-cycle pulse after final note
// BEHAVIOUR
//  - Async reset: state=IDLE; all outputs, beat counter, pos and snapshot regs = 0.
//  - States: IDLE, COUNTDOWN, PLAY, PAUSED, DONE. All outputs registered.
//  - IDLE: start & mode==PLAY_MODE -> latch note1/note2 into snapshot, cnt=0,
//    countdown=COUNTDOWN_BEATS, pos=0, next state COUNTDOWN (busy=1 one cycle after start).
//  - Beat event = (cnt==BEAT_CYCLES-1) in COUNTDOWN or PLAY. cnt increments each cycle in
//    those states and wraps to 0 on the beat. cnt is held in PAUSED and cleared in IDLE/DONE.
//  - COUNTDOWN: each beat decrements countdown; when the beat takes it to 0 -> PLAY.
//  - PLAY: each beat emits snapshot note[pos]. Next cycle cur_note=note, play_pos=pos,
//    note_valid=1; pos++. Beat with pos==SONG_LEN-1 emits it, then -> DONE.
//  - DONE: done=1, busy=0 for exactly one cycle, then IDLE. cur_note/play_pos hold.
//  - Latency: first note_valid (COUNTDOWN_BEATS+1)*BEAT_CYCLES cycles after start
//    strobe. Notes then every BEAT_CYCLES cycles.
//  - Pause strobe in COUNTDOWN/PLAY -> PAUSED; the return state is saved. Pause strobe in
//    PAUSED -> saved state, cnt resumes from its held value (beat phase preserved).
//  - Priority, highest first: mode!=PLAY_MODE (any busy state -> IDLE next cycle, no done,
//    countdown=0, note_valid=0) > pause > beat. A pause on a beat cycle wins: the beat is
//    not consumed and fires on the first cycle after resume (cnt held at BEAT_CYCLES-1).
//  - start ignored when busy or in DONE. pause ignored in IDLE/DONE.
//  - Song edits (note1/note2) during playback have no effect until next start.
//  - Note code 2'b00 (rest) is still emitted with note_valid; no filtering.
// TESTING (BEAT_CYCLES=4, COUNTDOWN_BEATS=2, SONG_LEN=32, PLAY_MODE=3)
//  - Reset: nrst low mid-PLAY -> all outputs 0 at once, IDLE; after release, start replays
//    from pos 0.
//  - Full play: note1=32'hE4E4E4E4, note2=32'h1B1B1B1B, start at t. Required:
//    countdown 2->1->0 at t+5/t+9.
//    note_valid at t+13+4k, cur_note 0,1,2,3,... (p<16) and 3,2,1,0,... (p>=16).
//    done=1 only at t+137. busy=0 from t+137.
//  - Pause: pause strobe at cycle cnt==3 of beat 5, hold 10 cycles, pause again ->
//    note 5 appears exactly 11 cycles late; no note skipped or duplicated.
//  - Abort: mode->0 during COUNTDOWN and during PAUSED -> IDLE next cycle, busy=0,
//    done never pulses, no further note_valid.
//  - Snapshot: change note1 to 0 after start -> emitted notes still match original words.
//  - Ignored inputs: start while busy, pause in IDLE, start with mode!=3 -> no state change.

Source files
------------

// File: rtl/song_sequencer.sv
// Playback controller: snapshots the 32-note song on start, counts in, then
// emits one note per beat with pause/resume and abort on leaving play mode.
module song_sequencer #(
    parameter int unsigned BEAT_CYCLES     = 25,
    parameter int unsigned COUNTDOWN_BEATS = 3,
    parameter int unsigned SONG_LEN        = 32,
    parameter logic [2:0]  PLAY_MODE       = 3'd3
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [2:0]  mode,
    input  logic        start,
    input  logic        pause,
    input  logic [31:0] note1,
    input  logic [31:0] note2,
    output logic [1:0]  cur_note,
    output logic        note_valid,
    output logic [4:0]  play_pos,
    output logic [1:0]  countdown,
    output logic        busy,
    output logic        paused,
    output logic        done
);

    localparam int unsigned CNT_W = $clog2(BEAT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNTDOWN,
        S_PLAY,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    state_t             ret_q, ret_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         pos_q, pos_d;
    logic [63:0]        snap_q, snap_d;
    logic [1:0]         cd_q, cd_d;
    logic [1:0]         cur_note_q, cur_note_d;
    logic [4:0]         play_pos_q, play_pos_d;
    logic [1:0]         countdown_q, countdown_d;
    logic               note_valid_q, note_valid_d;
    logic               busy_q, busy_d;
    logic               paused_q, paused_d;
    logic               done_q, done_d;
    logic               beat;
    logic               play_ok;

    // Next-state and registered-output logic; abort beats pause beats the beat.
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cnt_d        = cnt_q;
        pos_d        = pos_q;
        snap_d       = snap_q;
        cd_d         = cd_q;
        cur_note_d   = cur_note_q;
        play_pos_d   = play_pos_q;
        note_valid_d = 1'b0;
        beat         = (cnt_q == CNT_W'(BEAT_CYCLES - 1));
        play_ok      = (mode == PLAY_MODE);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start && play_ok) begin
                    snap_d  = {note2, note1};
                    cd_d    = 2'(COUNTDOWN_BEATS);
                    pos_d   = '0;
                    state_d = S_COUNTDOWN;
                end
            end
            S_COUNTDOWN, S_PLAY: begin
                if (!play_ok) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    cd_d    = '0;
                end else if (pause) begin
                    ret_d   = state_q;
                    state_d = S_PAUSED;
                end else begin
                    cnt_d = beat ? '0 : cnt_q + CNT_W'(1);
                    if (beat && state_q == S_COUNTDOWN) begin
                        cd_d = cd_q - 2'd1;
                        if (cd_q == 2'd1) begin
                            state_d = S_PLAY;
                        end
                    end else if (beat) begin
                        cur_note_d   = snap_q[{pos_q, 1'b0} +: 2];
                        play_pos_d   = pos_q;
                        note_valid_d = 1'b1;
                        pos_d        = pos_q + 5'd1;
                        if (pos_q == 5'(SONG_LEN - 1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_PAUSED: begin
                if (!play_ok) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    cd_d    = '0;
                end else if (pause) begin
                    state_d = ret_q;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        countdown_d = (state_d == S_COUNTDOWN) ? cd_d : 2'd0;
        busy_d      = (state_d == S_COUNTDOWN) || (state_d == S_PLAY) || (state_d == S_PAUSED);
        paused_d    = (state_d == S_PAUSED);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            ret_q        <= S_IDLE;
            cnt_q        <= '0;
            pos_q        <= '0;
            snap_q       <= '0;
            cd_q         <= '0;
            cur_note_q   <= '0;
            play_pos_q   <= '0;
            countdown_q  <= '0;
            note_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            paused_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            cnt_q        <= cnt_d;
            pos_q        <= pos_d;
            snap_q       <= snap_d;
            cd_q         <= cd_d;
            cur_note_q   <= cur_note_d;
            play_pos_q   <= play_pos_d;
            countdown_q  <= countdown_d;
            note_valid_q <= note_valid_d;
            busy_q       <= busy_d;
            paused_q     <= paused_d;
            done_q       <= done_d;
        end
    end

    assign cur_note   = cur_note_q;
    assign note_valid = note_valid_q;
    assign play_pos   = play_pos_q;
    assign countdown  = countdown_q;
    assign busy       = busy_q;
    assign paused     = paused_q;
    assign done       = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: beat-count model checked every cycle, plus
// literal timing/value expectations for play, pause, abort and reset.
module tb_song_sequencer;

    localparam int B = 4;
    localparam int C = 2;
    localparam int L = 32;

    logic        clk, nrst, start, pause;
    logic [2:0]  mode;
    logic [31:0] note1, note2;
    logic [1:0]  cur_note, countdown;
    logic        note_valid, busy, paused, done;
    logic [4:0]  play_pos;

    song_sequencer #(
        .BEAT_CYCLES(B), .COUNTDOWN_BEATS(C), .SONG_LEN(L), .PLAY_MODE(3'd3)
    ) dut (
        .clk(clk), .nrst(nrst), .mode(mode), .start(start), .pause(pause),
        .note1(note1), .note2(note2), .cur_note(cur_note), .note_valid(note_valid),
        .play_pos(play_pos), .countdown(countdown), .busy(busy), .paused(paused),
        .done(done)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int s = 0;
    bit chk_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: playback is a count of active (non-paused) cycles since start;
    // every B-th one is a beat, the first C beats count in, the next L emit notes.
    bit          m_act, m_paused, m_indone;
    int          m_t, mn, mj;
    logic [63:0] m_song;
    int e_cur, e_valid, e_pos, e_cd, e_busy, e_paused, e_done;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_act = 0; m_paused = 0; m_indone = 0; m_t = 0; m_song = '0;
            e_cur = 0; e_valid = 0; e_pos = 0; e_cd = 0; e_busy = 0; e_paused = 0; e_done = 0;
        end else begin
            e_valid = 0;
            e_done  = 0;
            if (m_indone) begin
                m_indone = 0;
            end else if (!m_act) begin
                if (start && mode == 3'd3) begin
                    m_act = 1; m_paused = 0; m_t = 0; m_song = {note2, note1};
                end
            end else if (mode != 3'd3) begin
                m_act = 0;
            end else if (pause) begin
                m_paused = !m_paused;
            end else if (!m_paused) begin
                m_t++;
                if (m_t % B == 0) begin
                    mn = m_t / B;
                    if (mn > C) begin
                        mj      = mn - C - 1;
                        e_cur   = int'(m_song[2*mj +: 2]);
                        e_pos   = mj;
                        e_valid = 1;
                        if (mj == L - 1) begin
                            m_act = 0; m_indone = 1; e_done = 1;
                        end
                    end
                end
            end
            e_busy   = int'(m_act);
            e_paused = int'(m_act && m_paused);
            e_cd     = (m_act && !m_paused && m_t < C * B) ? C - m_t / B : 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cur_note", int'(cur_note), e_cur);
            chk("note_valid", int'(note_valid), e_valid);
            chk("play_pos", int'(play_pos), e_pos);
            chk("countdown", int'(countdown), e_cd);
            chk("busy", int'(busy), e_busy);
            chk("paused", int'(paused), e_paused);
            chk("done", int'(done), e_done);
        end
    end

    // Event log of emitted notes and done pulses
    int nv_n = 0;
    int nv_cyc[64];
    int nv_note[64];
    int nv_pos[64];
    int done_cnt = 0;
    int done_cyc = 0;

    always @(posedge clk) begin
        #1;
        if (note_valid && nv_n < 64) begin
            nv_cyc[nv_n]  = cyc;
            nv_note[nv_n] = int'(cur_note);
            nv_pos[nv_n]  = int'(play_pos);
            nv_n++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_log();
        nv_n = 0;
        done_cnt = 0;
        done_cyc = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
    endtask

    task automatic wait_notes(input int n, input int max);
        int k = 0;
        while (nv_n < n && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("note_wait_timeout", int'(nv_n >= n), 1);
    endtask

    task automatic wait_done(input int max);
        int k = 0;
        while (done_cnt == 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("done_wait_timeout", int'(done_cnt > 0), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, int'({cur_note, note_valid, play_pos, countdown, busy, paused, done}), 0);
    endtask

    initial begin
        nrst = 1'b0; start = 1'b0; pause = 1'b0; mode = 3'd3;
        note1 = '0; note2 = '0;
        #1 chk_en = 1;
        step(3);
        chk_all_zero("reset");
        nrst = 1'b1;
        step(2);

        // Full play, with snapshot edits and a stray start while busy
        note1 = 32'hE4E4_E4E4; note2 = 32'h1B1B_1B1B;
        clear_log();
        s = cyc;
        pulse_start();
        note1 = 32'h0; note2 = 32'hFFFF_FFFF;
        chk("busy_after_start", int'(busy), 1);
        for (int i = 1; i <= 9; i++) begin
            chk("countdown_seq", int'(countdown), (i < 5) ? 2 : ((i < 9) ? 1 : 0));
            @(negedge clk);
        end
        step(20);
        pulse_start();
        wait_done(200);
        chk("busy_at_done", int'(busy), 0);
        step(4);
        chk("note_count", nv_n, 32);
        for (int j = 0; j < 32 && j < nv_n; j++) begin
            chk("note_time", nv_cyc[j] - s, 13 + 4 * j);
            chk("note_code", nv_note[j], (j < 16) ? (j % 4) : (3 - (j % 4)));
            chk("note_pos", nv_pos[j], j);
        end
        chk("done_time", done_cyc - s, 137);
        chk("done_count", done_cnt, 1);

        // Ignored inputs in IDLE
        pulse_pause();
        chk("idle_pause_busy", int'(busy), 0);
        chk("idle_pause_paused", int'(paused), 0);
        mode = 3'd5;
        pulse_start();
        chk("badmode_start_busy", int'(busy), 0);
        step(3);
        chk("badmode_start_cd", int'(countdown), 0);
        mode = 3'd3;

        // Pause on the beat cycle of note 5, resume 10 cycles later
        note1 = 32'hE4E4_E4E4; note2 = 32'h1B1B_1B1B;
        clear_log();
        s = cyc;
        pulse_start();
        wait_notes(5, 100);
        step(3);
        pulse_pause();
        chk("paused_lit", int'(paused), 1);
        step(9);
        pulse_pause();
        wait_notes(9, 100);
        if (nv_n >= 9) begin
            chk("pause_note5_gap", nv_cyc[5] - nv_cyc[4], 15);
            chk("pause_note6_gap", nv_cyc[6] - nv_cyc[5], 4);
            for (int j = 0; j < 9; j++) chk("pause_pos_seq", nv_pos[j], j);
            chk("pause_note5_code", nv_note[5], 1);
        end

        // Asynchronous reset mid-play, then replay from position 0
        #2 nrst = 1'b0;
        #1 chk_all_zero("midplay_reset");
        @(negedge clk);
        nrst = 1'b1;
        step(2);
        clear_log();
        s = cyc;
        pulse_start();
        wait_notes(1, 50);
        if (nv_n >= 1) begin
            chk("replay_time", nv_cyc[0] - s, 13);
            chk("replay_pos", nv_pos[0], 0);
            chk("replay_code", nv_note[0], 0);
        end

        // Abort while paused
        pulse_pause();
        step(3);
        mode = 3'd0;
        @(negedge clk);
        chk("abort_paused_busy", int'(busy), 0);
        chk("abort_paused_paused", int'(paused), 0);
        step(20);
        chk("abort_paused_notes", nv_n, 1);
        chk("abort_paused_done", done_cnt, 0);
        mode = 3'd3;
        step(2);

        // Abort during count-in
        clear_log();
        s = cyc;
        pulse_start();
        step(5);
        chk("abort_cd_pre", int'(countdown), 1);
        mode = 3'd0;
        @(negedge clk);
        chk("abort_cd_busy", int'(busy), 0);
        chk("abort_cd_countdown", int'(countdown), 0);
        step(20);
        chk("abort_cd_notes", nv_n, 0);
        chk("abort_cd_done", done_cnt, 0);
        mode = 3'd3;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
